// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage feeding write-back.
//
// Non-memory instructions flow straight into the MEM/WB register with one
// cycle of latency. Loads and stores are captured into internal op registers
// and run a request/response handshake with the data memory. While one is
// outstanding, stall is raised so that upstream holds EX/MEM.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   valid_in ..     EX/MEM fields (valid, mem_read, mem_write, reg_write_in,
//   write_data_in   wd_selector_in, rd_in, alu_result_in, write_data_in)
//   stall           stage busy (state != IDLE)
//   mem_req/we/     memory request channel; mem_ready accepts the request
//   addr/wdata
//   mem_rvalid/     memory response channel
//   mem_rdata
//   wb_valid ..     MEM/WB register; wb_valid pulses once per retirement
//   read_data
module mem_stage #(
  parameter int N = 32,
  parameter int A = 32,
  parameter int R = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         reg_write_in,
  input  logic         wd_selector_in,
  input  logic [R-1:0] rd_in,
  input  logic [N-1:0] alu_result_in,
  input  logic [N-1:0] write_data_in,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata,
  output logic         wb_valid,
  output logic         reg_write,
  output logic         wd_selector,
  output logic [R-1:0] rd,
  output logic [N-1:0] alu_result,
  output logic [N-1:0] read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Latched memory operation
  logic         op_we_reg;
  logic         op_reg_write_reg;
  logic         op_wd_sel_reg;
  logic [R-1:0] op_rd_reg;
  logic [N-1:0] op_alu_reg;
  logic [N-1:0] op_wdata_reg;

  // MEM/WB register
  logic         wb_valid_reg;
  logic         reg_write_reg;
  logic         wd_selector_reg;
  logic [R-1:0] rd_reg;
  logic [N-1:0] alu_result_reg;
  logic [N-1:0] read_data_reg;

  logic is_mem_op;
  logic capture;      // latch EX/MEM into the op registers
  logic retire_alu;   // retire straight from the EX/MEM inputs
  logic retire_op;    // retire from the latched op registers
  logic load_data;    // capture mem_rdata into read_data

  assign is_mem_op = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    retire_alu = 1'b0;
    retire_op  = 1'b0;
    load_data  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (valid_in) begin
          if (is_mem_op) begin
            capture    = 1'b1;
            state_next = REQ;
          end else begin
            retire_alu = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (op_we_reg) begin
            retire_op  = 1'b1;
            state_next = IDLE;
          end else if (mem_rvalid) begin
            // Grant and data in the same cycle: skip RESP entirely
            retire_op  = 1'b1;
            load_data  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          retire_op  = 1'b1;
          load_data  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_we_reg        <= 1'b0;
      op_reg_write_reg <= 1'b0;
      op_wd_sel_reg    <= 1'b0;
      op_rd_reg        <= '0;
      op_alu_reg       <= '0;
      op_wdata_reg     <= '0;
    end else if (capture) begin
      // A load+store combination is treated as a load
      op_we_reg        <= mem_write & ~mem_read;
      op_reg_write_reg <= reg_write_in;
      op_wd_sel_reg    <= wd_selector_in;
      op_rd_reg        <= rd_in;
      op_alu_reg       <= alu_result_in;
      op_wdata_reg     <= write_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg    <= 1'b0;
      reg_write_reg   <= 1'b0;
      wd_selector_reg <= 1'b0;
      rd_reg          <= '0;
      alu_result_reg  <= '0;
      read_data_reg   <= '0;
    end else begin
      wb_valid_reg <= retire_alu | retire_op;
      if (retire_alu) begin
        reg_write_reg   <= reg_write_in;
        wd_selector_reg <= wd_selector_in;
        rd_reg          <= rd_in;
        alu_result_reg  <= alu_result_in;
      end else if (retire_op) begin
        reg_write_reg   <= op_reg_write_reg;
        wd_selector_reg <= op_wd_sel_reg;
        rd_reg          <= op_rd_reg;
        alu_result_reg  <= op_alu_reg;
      end
      if (load_data) begin
        read_data_reg <= mem_rdata;
      end
    end
  end

  // Request outputs are qualified by REQ so they read as zero when idle
  assign stall     = (state_reg != IDLE);
  assign mem_req   = (state_reg == REQ);
  assign mem_we    = mem_req & op_we_reg;
  assign mem_addr  = mem_req ? op_alu_reg[A-1:0] : '0;
  assign mem_wdata = mem_req ? op_wdata_reg : '0;

  assign wb_valid    = wb_valid_reg;
  assign reg_write   = reg_write_reg;
  assign wd_selector = wd_selector_reg;
  assign rd          = rd_reg;
  assign alu_result  = alu_result_reg;
  assign read_data   = read_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int N = 32;
  localparam int A = 32;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic         reg_write_in = 1'b0, wd_selector_in = 1'b0;
  logic [R-1:0] rd_in = '0;
  logic [N-1:0] alu_result_in = '0, write_data_in = '0;
  logic         stall, mem_req, mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [N-1:0] mem_rdata = '0;
  logic         wb_valid, reg_write, wd_selector;
  logic [R-1:0] rd;
  logic [N-1:0] alu_result, read_data;

  int errors = 0;
  int checks = 0;

  // Architectural view of the MEM/WB register expected after each retirement
  logic         exp_rw, exp_wds;
  logic [R-1:0] exp_rd;
  logic [N-1:0] exp_alu, exp_rdata;

  mem_stage #(.N(N), .A(A), .R(R)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write_in(reg_write_in),
    .wd_selector_in(wd_selector_in), .rd_in(rd_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .reg_write(reg_write),
    .wd_selector(wd_selector), .rd(rd), .alu_result(alu_result),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble_inputs();
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    reg_write_in = 1'($urandom); wd_selector_in = 1'($urandom);
    rd_in = R'($urandom); alu_result_in = $urandom; write_data_in = $urandom;
  endtask

  // Checks the MEM/WB register right after a retirement edge.
  task automatic check_retire(input string name);
    checks++;
    if (wb_valid !== 1'b1 || reg_write !== exp_rw || wd_selector !== exp_wds ||
        rd !== exp_rd || alu_result !== exp_alu || read_data !== exp_rdata || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s retire: got v=%b rw=%b wds=%b rd=%0d alu=%h rdata=%h stall=%b, required v=1 rw=%b wds=%b rd=%0d alu=%h rdata=%h stall=0",
               name, wb_valid, reg_write, wd_selector, rd, alu_result, read_data, stall,
               exp_rw, exp_wds, exp_rd, exp_alu, exp_rdata);
    end
  endtask

  // Issues one instruction at a negedge in IDLE and follows it to retirement.
  // rdy_dly: cycles in REQ before grant; rv_dly: cycles after grant until
  // rvalid for loads (0 = same cycle as grant).
  task automatic run_op(input string name, input logic mr, input logic mw, input logic rw,
                        input logic wds, input logic [R-1:0] r, input logic [N-1:0] alu,
                        input logic [N-1:0] wd, input int rdy_dly, input int rv_dly);
    logic is_mem, is_store;
    logic [N-1:0] rdata;
    is_mem = mr | mw;
    is_store = mw & ~mr;
    valid_in = 1'b1; mem_read = mr; mem_write = mw; reg_write_in = rw;
    wd_selector_in = wds; rd_in = r; alu_result_in = alu; write_data_in = wd;
    step();
    valid_in = 1'b0;
    if (!is_mem) begin
      exp_rw = rw; exp_wds = wds; exp_rd = r; exp_alu = alu;
      check_retire(name);
      return;
    end
    scramble_inputs();  // op must have been latched
    for (int i = 0; i <= rdy_dly; i++) begin
      checks++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || wb_valid !== 1'b0 || mem_we !== is_store ||
          mem_addr !== alu[A-1:0] || mem_wdata !== wd) begin
        errors++;
        $display("FAIL %s req[%0d]: got req=%b stall=%b wbv=%b we=%b addr=%h wdata=%h, required req=1 stall=1 wbv=0 we=%b addr=%h wdata=%h",
                 name, i, mem_req, stall, wb_valid, mem_we, mem_addr, mem_wdata, is_store, alu[A-1:0], wd);
      end
      mem_ready = (i == rdy_dly);
      rdata = $urandom;
      mem_rdata = rdata;
      mem_rvalid = !is_store && rv_dly == 0 && i == rdy_dly;
      step();
    end
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (!is_store && rv_dly > 0) begin
      for (int j = 1; j <= rv_dly; j++) begin
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s resp[%0d]: got req=%b stall=%b wbv=%b, required req=0 stall=1 wbv=0",
                   name, j, mem_req, stall, wb_valid);
        end
        rdata = $urandom;
        mem_rdata = rdata;
        mem_rvalid = (j == rv_dly);
        step();
      end
      mem_rvalid = 1'b0;
    end
    exp_rw = rw; exp_wds = wds; exp_rd = r; exp_alu = alu;
    if (!is_store) exp_rdata = rdata;
    check_retire(name);
    $display("op %s mr=%b mw=%b addr=%h rdy_dly=%0d rv_dly=%0d", name, mr, mw, alu, rdy_dly, rv_dly);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; mem_read = 1'b1; alu_result_in = 32'h55;
    step(); step();
    checks++;
    if (stall !== 0 || mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 ||
        wb_valid !== 0 || reg_write !== 0 || wd_selector !== 0 || rd !== 0 ||
        alu_result !== 0 || read_data !== 0) begin
      errors++;
      $display("FAIL reset: got stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b rw=%b wds=%b rd=%0d alu=%h rdata=%h, required all 0",
               stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, reg_write, wd_selector, rd, alu_result, read_data);
    end
    rst = 1'b0; valid_in = 1'b0; mem_read = 1'b0;
    exp_rw = 0; exp_wds = 0; exp_rd = 0; exp_alu = 0; exp_rdata = 0;
    $display("reset done");
  endtask

  task automatic test_alu();
    run_op("alu", 0, 0, 1, 0, 5'd7, 32'h0000_00FF, 32'h0, 0, 0);
    step();
    checks++;
    if (wb_valid !== 1'b0 || alu_result !== 32'hFF || rd !== 5'd7) begin
      errors++;
      $display("FAIL alu_hold: got wbv=%b alu=%h rd=%0d, required wbv=0 alu=000000ff rd=7", wb_valid, alu_result, rd);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++)
      run_op("b2b_alu", 0, 0, 1'($urandom), 1'($urandom), R'($urandom), $urandom, $urandom, 0, 0);
  endtask

  task automatic test_load();
    run_op("load_slow", 1, 0, 1, 1, 5'd3, 32'h100, 32'h0, 3, 2);
    run_op("load_fast", 1, 0, 1, 1, 5'd4, 32'h104, 32'h0, 0, 0);
  endtask

  task automatic test_store();
    run_op("store", 0, 1, 0, 0, 5'd0, 32'h40, 32'h1234_5678, 0, 0);
    run_op("load_store", 1, 1, 1, 1, 5'd9, 32'h80, 32'hCAFE_0000, 1, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), R'($urandom),
             $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_in_resp();
    // Fresh reset so read_data is known to be 0 beforehand
    rst = 1'b1; step(); rst = 1'b0;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result_in = 32'h200; rd_in = 5'd11;
    step();
    valid_in = 1'b0; mem_read = 1'b0;
    mem_ready = 1'b1; step(); mem_ready = 1'b0;  // grant, now in RESP
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (mem_req !== 0 || stall !== 0 || wb_valid !== 0) begin
      errors++;
      $display("FAIL rst_resp: got req=%b stall=%b wbv=%b, required 0 0 0", mem_req, stall, wb_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; step(); mem_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 0 || read_data !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL late_rvalid: got wbv=%b rdata=%h stall=%b, required 0 00000000 0", wb_valid, read_data, stall);
    end
    $display("reset in RESP done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_random();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that produces the operands consumed by write-back: the ALU result and the memory read data.
- Holds the MEM/WB pipeline register.
- Runs a request/response handshake with the data memory and raises a stall to the upstream stages while a load or store is outstanding.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- N, 32, data width in bits (ALU result, store data, read data).
- A, 32, memory address width; A <= N.
- R, 5, destination-register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  EX/MEM holds a valid instruction.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- reg_write_in  input  1  instruction writes the register file.
- wd_selector_in  input  1  write-back source: 0 = ALU result, 1 = read data.
- rd_in  input  R  destination register index.
- alu_result_in  input  N  ALU result; also the memory address.
- write_data_in  input  N  store data.
- stall  output  1  stage busy; upstream must hold EX/MEM.
- mem_req  output  1  memory request valid.
- mem_we  output  1  request is a write.
- mem_addr  output  A  request address (alu_result[A-1:0]).
- mem_wdata  output  N  store data.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  N  read data.
- wb_valid  output  1  one-cycle pulse: MEM/WB updated with a retired instruction.
- reg_write  output  1  registered reg_write for write-back.
- wd_selector  output  1  registered write-back select.
- rd  output  R  registered destination index.
- alu_result  output  N  registered ALU result.
- read_data  output  N  registered load data.

Behaviour:
- Reset: state IDLE; all outputs 0, including the MEM/WB register and memory-request outputs. Reset mid-transaction abandons the request; mem_req is 0 from the cycle after the reset edge.
- stall = (state != IDLE), combinational from state only.
- valid_in is sampled only in IDLE.
- A memory op is mem_read | mem_write. If both are asserted, the instruction is treated as a load and mem_we = 0.
- IDLE, valid_in=1, not a memory op:
  - next edge loads rd, reg_write, wd_selector, alu_result into MEM/WB; read_data holds its old value; wb_valid=1 for that cycle.
  - state stays IDLE. Latency 1, throughput 1/cycle.
- IDLE, valid_in=1, memory op:
  - latch all inputs into internal op registers; go to REQ; no wb_valid.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata driven from the latched op and stable until accepted.
  - mem_ready=0: stay in REQ.
  - mem_ready=1, store: retire (MEM/WB loaded, wb_valid pulse); go to IDLE.
  - mem_ready=1, load, mem_rvalid=1 in the same cycle: capture mem_rdata into read_data, retire, go to IDLE.
  - mem_ready=1, load, mem_rvalid=0: go to RESP.
- RESP:
  - mem_req=0.
  - On mem_rvalid: capture mem_rdata into read_data, retire, go to IDLE. Otherwise wait indefinitely.
- mem_rvalid outside REQ/RESP, including after a reset-abandoned load: ignored.
- wb_valid is high for exactly one cycle per retired instruction. Other MEM/WB fields hold between retirements.
- Minimum load latency (issue to wb_valid) is 2 cycles: 1 cycle IDLE->REQ, then 1 cycle when ready and rvalid arrive together. Minimum store latency is 2 cycles.
- No alignment checking; address is a straight truncation of alu_result.

Test Plan:
- Reset: hold rst=1 for 2 cycles with valid_in=1 -> all outputs 0, stall=0, mem_req=0.
- ALU op: valid_in=1, mem_read=0, mem_write=0, alu_result_in=0x0000_00FF, rd_in=7, reg_write_in=1 -> next cycle wb_valid=1, alu_result=0xFF, rd=7, stall=0. Back-to-back ALU ops retire one per cycle.
- Load, 3-cycle ready delay, rvalid 2 cycles after grant, mem_rdata=0xDEAD_BEEF, alu_result_in=0x100:
  - mem_req=1, mem_we=0, mem_addr=0x100 held until ready.
  - stall=1 throughout.
  - read_data=0xDEADBEEF with wb_valid pulse, then stall=0.
- Load with mem_ready and mem_rvalid in the same cycle -> completes with no RESP cycle; wb_valid exactly 2 cycles after acceptance.
- Store: mem_write=1, write_data_in=0x1234_5678, addr 0x40, immediate ready -> mem_we=1, mem_wdata=0x12345678 for one cycle; wb_valid next edge.
- Simultaneous mem_read and mem_write -> mem_we=0.
- Reset asserted in RESP:
  - next cycle IDLE, mem_req=0, no wb_valid.
  - a late mem_rvalid is ignored and read_data stays 0.
